// File: rtl/local_energy_accum.sv
// Chunked local-energy engine: E_i = s_i * (sum_j J_ij*s_j + h_i*scale_i), weights streamed PARALLELISM per beat.
// Define ENERGY_SATURATE_EN to clamp out-of-range results; otherwise they wrap (overflow_o flags both). scale_i is an unsigned magnitude.
module local_energy_accum #(
  parameter int BITJ             = 4,
  parameter int BITH             = 4,
  parameter int DATASPIN         = 256,
  parameter int SCALING_BIT      = 5,
  parameter int LOCAL_ENERGY_BIT = 16,
  parameter int PARALLELISM      = 16
) (
  input  logic                          clk_i,
  input  logic                          rst_ni,
  input  logic                          flush_i,
  input  logic                          start_valid_i,
  output logic                          start_ready_o,
  input  logic [DATASPIN-1:0]           spin_vector_i,
  input  logic                          current_spin_i,
  input  logic [BITH-1:0]               hbias_i,
  input  logic [SCALING_BIT-1:0]        hscaling_i,
  input  logic                          weight_valid_i,
  output logic                          weight_ready_o,
  input  logic [PARALLELISM*BITJ-1:0]   weight_i,
  output logic                          energy_valid_o,
  input  logic                          energy_ready_i,
  output logic [LOCAL_ENERGY_BIT-1:0]   energy_o,
  output logic                          busy_o,
  output logic                          overflow_o
);

  localparam int NUM_BEATS = DATASPIN / PARALLELISM;
  localparam int CNT_W     = $clog2(NUM_BEATS + 1);
  localparam int SUM_W     = BITJ + $clog2(DATASPIN);
  localparam int BIAS_W    = BITH + SCALING_BIT;
  localparam int ACC_W     = ((SUM_W > BIAS_W) ? SUM_W : BIAS_W) + 2;
  localparam int FIT_W     = (ACC_W > LOCAL_ENERGY_BIT) ? ACC_W : LOCAL_ENERGY_BIT;

  localparam logic signed [FIT_W-1:0] E_MAX =
    {{(FIT_W-LOCAL_ENERGY_BIT+1){1'b0}}, {(LOCAL_ENERGY_BIT-1){1'b1}}};
  localparam logic signed [FIT_W-1:0] E_MIN =
    {{(FIT_W-LOCAL_ENERGY_BIT+1){1'b1}}, {(LOCAL_ENERGY_BIT-1){1'b0}}};

  if (DATASPIN % PARALLELISM != 0) begin : g_param_check
    $fatal(1, "DATASPIN must be a multiple of PARALLELISM");
  end

  typedef enum logic [1:0] {S_IDLE, S_ACCUM, S_FINAL, S_DONE} state_e;

  state_e                        state_q, state_d;
  logic [DATASPIN-1:0]           spin_q, spin_d;
  logic                          cur_spin_q, cur_spin_d;
  logic [BITH-1:0]               hbias_q, hbias_d;
  logic [SCALING_BIT-1:0]        hscale_q, hscale_d;
  logic signed [ACC_W-1:0]       acc_q, acc_d;
  logic [CNT_W-1:0]              cnt_q, cnt_d;
  logic [LOCAL_ENERGY_BIT-1:0]   energy_q, energy_d;
  logic                          ovf_q, ovf_d;

  logic signed [ACC_W-1:0]       beat_sum;
  logic signed [ACC_W-1:0]       bias_term;
  logic signed [ACC_W-1:0]       sum_pre;
  logic signed [ACC_W-1:0]       total;
  logic signed [FIT_W-1:0]       fit_val;
  logic [LOCAL_ENERGY_BIT-1:0]   fitted;
  logic                          fit_ovf;

  // Spins are consumed from the low end; spin_q shifts down one chunk per beat.
  always_comb begin
    beat_sum = '0;
    for (int k = 0; k < PARALLELISM; k++) begin
      if (spin_q[k]) beat_sum = beat_sum + ACC_W'(signed'(weight_i[k*BITJ +: BITJ]));
      else           beat_sum = beat_sum - ACC_W'(signed'(weight_i[k*BITJ +: BITJ]));
    end
  end

  assign bias_term = ACC_W'(signed'(hbias_q)) * $signed({{(ACC_W-SCALING_BIT){1'b0}}, hscale_q});
  assign sum_pre   = acc_q + bias_term;
  assign total     = cur_spin_q ? sum_pre : -sum_pre;
  assign fit_val   = FIT_W'(total);

  always_comb begin
    fit_ovf = (fit_val > E_MAX) || (fit_val < E_MIN);
`ifdef ENERGY_SATURATE_EN
    if (fit_val > E_MAX)      fitted = E_MAX[LOCAL_ENERGY_BIT-1:0];
    else if (fit_val < E_MIN) fitted = E_MIN[LOCAL_ENERGY_BIT-1:0];
    else                      fitted = fit_val[LOCAL_ENERGY_BIT-1:0];
`else
    fitted = fit_val[LOCAL_ENERGY_BIT-1:0];
`endif
  end

  // NOTE: every output and _d is given a default before the case so no latch is inferred.
  always_comb begin
    state_d        = state_q;
    spin_d         = spin_q;
    cur_spin_d     = cur_spin_q;
    hbias_d        = hbias_q;
    hscale_d       = hscale_q;
    acc_d          = acc_q;
    cnt_d          = cnt_q;
    energy_d       = energy_q;
    ovf_d          = ovf_q;
    start_ready_o  = 1'b0;
    weight_ready_o = 1'b0;
    if (flush_i) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE: begin
          start_ready_o = 1'b1;
          if (start_valid_i) begin
            spin_d     = spin_vector_i;
            cur_spin_d = current_spin_i;
            hbias_d    = hbias_i;
            hscale_d   = hscaling_i;
            acc_d      = '0;
            cnt_d      = '0;
            state_d    = S_ACCUM;
          end
        end
        S_ACCUM: begin
          weight_ready_o = 1'b1;
          if (weight_valid_i) begin
            acc_d  = acc_q + beat_sum;
            spin_d = spin_q >> PARALLELISM;
            cnt_d  = cnt_q + CNT_W'(1);
            if (cnt_q == CNT_W'(NUM_BEATS - 1)) state_d = S_FINAL;
          end
        end
        S_FINAL: begin
          energy_d = fitted;
          ovf_d    = fit_ovf;
          state_d  = S_DONE;
        end
        S_DONE: begin
          if (energy_ready_i) state_d = S_IDLE;
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  // NOTE: state registers use non-blocking assignments; combinational blocks above use blocking.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= S_IDLE;
      // NOTE: the wide spin register is reset too, so no stale operand is visible after reset.
      spin_q     <= '0;
      cur_spin_q <= 1'b0;
      hbias_q    <= '0;
      hscale_q   <= '0;
      acc_q      <= '0;
      cnt_q      <= '0;
      energy_q   <= '0;
      ovf_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      spin_q     <= spin_d;
      cur_spin_q <= cur_spin_d;
      hbias_q    <= hbias_d;
      hscale_q   <= hscale_d;
      acc_q      <= acc_d;
      cnt_q      <= cnt_d;
      energy_q   <= energy_d;
      ovf_q      <= ovf_d;
    end
  end

  assign energy_valid_o = (state_q == S_DONE);
  assign busy_o         = (state_q != S_IDLE);
  assign energy_o       = energy_q;
  assign overflow_o     = ovf_q;

endmodule

// File: tb/tb_local_energy_accum.sv
// Randomised self-checking bench for local_energy_accum; a 16-bit and a 10-bit output instance run in lockstep.
module tb_local_energy_accum;
  localparam int BITJ = 4, BITH = 4, DATASPIN = 256, SCALING_BIT = 5, PAR = 16;
  localparam int NB = DATASPIN / PAR;

  logic clk = 1'b0, rst_n = 1'b0;
  logic flush_i = 0, start_valid_i = 0, current_spin_i = 0, weight_valid_i = 0, energy_ready_i = 0;
  logic [DATASPIN-1:0]    spin_vector_i = '0;
  logic [BITH-1:0]        hbias_i = '0;
  logic [SCALING_BIT-1:0] hscaling_i = '0;
  logic [PAR*BITJ-1:0]    weight_i = '0;

  logic start_ready_a, weight_ready_a, energy_valid_a, busy_a, overflow_a;
  logic start_ready_b, weight_ready_b, energy_valid_b, busy_b, overflow_b;
  logic [15:0] energy_a;
  logic [9:0]  energy_b;

  int n_tests = 0, n_fail = 0;

  always #5 clk = ~clk;

  local_energy_accum #(.LOCAL_ENERGY_BIT(16)) u_dut (
    .clk_i(clk), .rst_ni(rst_n), .flush_i(flush_i),
    .start_valid_i(start_valid_i), .start_ready_o(start_ready_a),
    .spin_vector_i(spin_vector_i), .current_spin_i(current_spin_i),
    .hbias_i(hbias_i), .hscaling_i(hscaling_i),
    .weight_valid_i(weight_valid_i), .weight_ready_o(weight_ready_a), .weight_i(weight_i),
    .energy_valid_o(energy_valid_a), .energy_ready_i(energy_ready_i), .energy_o(energy_a),
    .busy_o(busy_a), .overflow_o(overflow_a));

  local_energy_accum #(.LOCAL_ENERGY_BIT(10)) u_dut10 (
    .clk_i(clk), .rst_ni(rst_n), .flush_i(flush_i),
    .start_valid_i(start_valid_i), .start_ready_o(start_ready_b),
    .spin_vector_i(spin_vector_i), .current_spin_i(current_spin_i),
    .hbias_i(hbias_i), .hscaling_i(hscaling_i),
    .weight_valid_i(weight_valid_i), .weight_ready_o(weight_ready_b), .weight_i(weight_i),
    .energy_valid_o(energy_valid_b), .energy_ready_i(energy_ready_i), .energy_o(energy_b),
    .busy_o(busy_b), .overflow_o(overflow_b));

  task automatic check(input string name, input longint act, input longint exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Signed value fitted to w bits, saturating or wrapping like the build under test.
  function automatic void fit(input int e, input int w, output int v, output bit o);
    int hi = (1 << (w - 1)) - 1;
    int lo = -(1 << (w - 1));
    int m  = 1 << w;
    o = (e > hi) || (e < lo);
`ifdef ENERGY_SATURATE_EN
    v = (e > hi) ? hi : ((e < lo) ? lo : e);
`else
    v = ((e % m) + m) % m;
    if (v > hi) v -= m;
`endif
  endfunction

  // Reference model: one operation in flight, its beats, and whether its result is on the output.
  bit m_active = 0, m_present = 0, m_si = 0;
  int m_beats = 0, m_acc = 0, m_h = 0, m_scale = 0, m_last_e = 0;
  int m_e16 = 0, m_e10 = 0;
  bit m_o16 = 0, m_o10 = 0;
  logic [DATASPIN-1:0] m_spin = '0;

  always @(negedge clk) begin
    if (!rst_n) begin
      check("rst_ctrl_a", {busy_a, energy_valid_a, weight_ready_a, start_ready_a}, 4'b0001);
      check("rst_ctrl_b", {busy_b, energy_valid_b, weight_ready_b, start_ready_b}, 4'b0001);
      check("rst_out_a", {energy_a, overflow_a}, 0);
      check("rst_out_b", {energy_b, overflow_b}, 0);
      m_active = 0;
      m_present = 0;
    end else begin
      logic [3:0] exp_ctrl;
      exp_ctrl = {m_active, m_active && m_present,
                  m_active && !m_present && (m_beats < NB) && !flush_i,
                  !m_active && !flush_i};
      check("ctrl_a", {busy_a, energy_valid_a, weight_ready_a, start_ready_a}, exp_ctrl);
      check("ctrl_b", {busy_b, energy_valid_b, weight_ready_b, start_ready_b}, exp_ctrl);
      if (m_active && m_present) begin
        check("energy16", $signed(energy_a), m_e16);
        check("ovf16", overflow_a, m_o16);
        check("energy10", $signed(energy_b), m_e10);
        check("ovf10", overflow_b, m_o10);
      end
      if (flush_i) begin
        m_active = 0;
      end else if (!m_active) begin
        if (start_valid_i) begin
          m_active = 1; m_present = 0; m_beats = 0; m_acc = 0;
          m_spin = spin_vector_i; m_si = current_spin_i;
          m_h = $signed(hbias_i); m_scale = int'(hscaling_i);
        end
      end else if (m_beats < NB) begin
        if (weight_valid_i) begin
          for (int k = 0; k < PAR; k++) begin
            logic signed [BITJ-1:0] lane;
            lane = weight_i[k*BITJ +: BITJ];
            m_acc += m_spin[m_beats*PAR + k] ? int'(lane) : -int'(lane);
          end
          m_beats++;
        end
      end else if (!m_present) begin
        m_last_e = m_acc + m_h * m_scale;
        if (!m_si) m_last_e = -m_last_e;
        fit(m_last_e, 16, m_e16, m_o16);
        fit(m_last_e, 10, m_e10, m_o10);
        m_present = 1;
      end else if (energy_ready_i) begin
        m_active = 0;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start(input logic [DATASPIN-1:0] sp, input bit si,
                          input logic [BITH-1:0] h, input logic [SCALING_BIT-1:0] sc);
    int n = 0;
    bit ok = 0;
    spin_vector_i = sp; current_spin_i = si; hbias_i = h; hscaling_i = sc;
    start_valid_i = 1;
    while (!ok && n < 50) begin
      @(negedge clk);
      if (start_ready_a) ok = 1;
      n++;
    end
    check("start_handshake", ok, 1);
    tick();
    start_valid_i = 0;
    spin_vector_i = ~sp; current_spin_i = ~si; hbias_i = ~h; hscaling_i = ~sc;
  endtask

  task automatic send_beats(input int nbeats, input int wconst, input bit rnd_w,
                            input int gap_pct, output int accepted);
    int guard = 0;
    accepted = 0;
    while (accepted < nbeats && guard < 2000) begin
      weight_valid_i = ($urandom_range(99) >= gap_pct);
      for (int k = 0; k < PAR; k++)
        weight_i[k*BITJ +: BITJ] = rnd_w ? BITJ'($urandom) : BITJ'(wconst);
      @(negedge clk);
      if (weight_valid_i && weight_ready_a) accepted++;
      tick();
      guard++;
    end
    weight_valid_i = 0;
    weight_i = {$urandom, $urandom};
  endtask

  task automatic get_result(input int hold, output int e16, output int o16,
                            output int e10, output int o10);
    int guard = 0;
    bit ok = 0;
    energy_ready_i = 0;
    while (!ok && guard < 100) begin
      @(negedge clk);
      if (energy_valid_a) ok = 1;
      guard++;
    end
    check("result_valid", ok, 1);
    e16 = $signed(energy_a); o16 = overflow_a;
    e10 = $signed(energy_b); o10 = overflow_b;
    repeat (hold) @(negedge clk);
    tick();
    energy_ready_i = 1;
    tick();
    energy_ready_i = 0;
  endtask

  function automatic logic [DATASPIN-1:0] rand_spins();
    logic [DATASPIN-1:0] s;
    for (int i = 0; i < DATASPIN / 32; i++) s[i*32 +: 32] = $urandom;
    return s;
  endfunction

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int acc, e16, o16, e10, o10, saw;
    logic [DATASPIN-1:0] alt;
    alt = {128{2'b01}};
    repeat (3) @(posedge clk);
    #1 rst_n = 1;
    tick();

    // All-zero operands
    do_start('0, 0, 4'd0, 5'd1);
    send_beats(NB, 0, 0, 0, acc);
    check("t1_beats", acc, NB);
    get_result(0, e16, o16, e10, o10);
    check("t1_energy", e16, 0);
    check("t1_ovf", o16, 0);

    // Alternating spins: weights cancel, bias term dominates
    do_start(alt, 0, 4'($signed(-7)), 5'd16);
    send_beats(NB, -7, 0, 0, acc);
    get_result(0, e16, o16, e10, o10);
    check("t2_energy", e16, 112);
    check("t2_model", m_last_e, 112);

    // Maximum positive row sum
    do_start('1, 1, 4'd0, 5'd1);
    send_beats(NB, 7, 0, 0, acc);
    get_result(0, e16, o16, e10, o10);
    check("t3_energy", e16, 1792);
    check("t3_ovf", o16, 0);
    check("t3_model", m_last_e, 1792);
`ifdef ENERGY_SATURATE_EN
    check("t6_energy10", e10, 511);
`else
    check("t6_energy10", e10, -256);
`endif
    check("t6_ovf10", o10, 1);

    // Same with valid gaps and a stalled consumer
    do_start('1, 1, 4'd0, 5'd1);
    send_beats(NB, 7, 0, 40, acc);
    check("t4_beats", acc, NB);
    get_result(5, e16, o16, e10, o10);
    check("t4_energy", e16, 1792);

    // Flush after 8 beats, with a beat offered in the flush cycle
    do_start(alt, 0, 4'($signed(-7)), 5'd16);
    send_beats(8, -7, 0, 0, acc);
    flush_i = 1; weight_valid_i = 1;
    tick();
    flush_i = 0; weight_valid_i = 0;
    @(negedge clk);
    check("flush_idle", busy_a, 0);
    saw = 0;
    repeat (20) begin
      @(negedge clk);
      saw |= energy_valid_a;
    end
    check("flush_no_valid", saw, 0);
    tick();

    // Reset mid-accumulation
    do_start('1, 1, 4'd0, 5'd1);
    send_beats(5, 7, 0, 0, acc);
    rst_n = 0;
    @(negedge clk);
    check("rst_mid", {busy_a, energy_valid_a, weight_ready_a, start_ready_a, energy_a}, 20'h10000);
    tick();
    rst_n = 1;
    tick();

    do_start(alt, 0, 4'($signed(-7)), 5'd16);
    send_beats(NB, -7, 0, 0, acc);
    get_result(0, e16, o16, e10, o10);
    check("t5_energy", e16, 112);

    // Randomised operands, weights, gaps and stalls
    for (int r = 0; r < 15; r++) begin
      do_start(rand_spins(), 1'($urandom), BITH'($urandom), SCALING_BIT'($urandom));
      send_beats(NB, 0, 1, 30, acc);
      get_result($urandom_range(3), e16, o16, e10, o10);
    end

    repeat (3) tick();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
